csr_bank: RTL and testbench

- Parametrised JTAG-accessible CSR bank; next generation of the fixed 4x32 CSR block.
- Sits between the JTAG TAP data registers (TCK domain, async to sys_clk) and system logic in the sys_clk domain.
- Adds configurable register count and width, per-register read-only status inputs, write strobes, a per-register reset-value vector and read-data snapshotting.

---
 rtl/csr_bank_if.sv | 23 ++
 rtl/csr_bank.sv | 156 +++++++++++++++
 tb/tb_csr_bank.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_bank_if.sv
// JTAG-side access bus of csr_bank: TAP data-register levels in, latched
// address and read snapshot back out for Capture-DR.
interface csr_bank_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 32
);
  logic              dr_csr_addr_valid;
  logic [ADDR_W:0]   dr_csr_addr;
  logic              dr_csr_data_valid;
  logic [DATA_W-1:0] dr_csr_data;
  logic [ADDR_W:0]   csr_addr;
  logic [DATA_W-1:0] csr_data;

  modport master (
    output dr_csr_addr_valid, dr_csr_addr, dr_csr_data_valid, dr_csr_data,
    input  csr_addr, csr_data
  );

  modport slave (
    input  dr_csr_addr_valid, dr_csr_addr, dr_csr_data_valid, dr_csr_data,
    output csr_addr, csr_data
  );
endinterface

// File: rtl/csr_bank.sv
// Parametrised JTAG-accessible CSR bank with RO status registers, write strobes
// and a stable read snapshot. Optional sticky error flag: CSR_BANK_ERR_EN.
module csr_bank #(
  parameter int unsigned                NUM_REGS = 8,
  parameter int unsigned                DATA_W   = 32,
  parameter int unsigned                ADDR_W   = $clog2(NUM_REGS),
  parameter logic [NUM_REGS-1:0]        RO_MASK  = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL  = '0
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  csr_bank_if.slave                    bus,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_status,
  output logic [NUM_REGS*DATA_W-1:0]   csr_q,
  output logic [NUM_REGS-1:0]          csr_wr_pulse,
  output logic                         csr_err
);
  typedef enum logic {S_IDLE, S_ARMED} state_e;

  // Highest writable index; a write-1 to bit 0 there clears the error flag.
  function automatic int unsigned top_rw_idx();
    int unsigned t = 0;
    for (int unsigned i = 0; i < NUM_REGS; i++) if (!RO_MASK[i]) t = i;
    return t;
  endfunction
  localparam int unsigned TOP_RW = top_rw_idx();

  state_e              state_q;
  logic                addr_pls, data_pls;
  logic [ADDR_W:0]     addr_q;
  logic [ADDR_W-1:0]   idx;
  logic [DATA_W-1:0]   data_q, rd_val;
  logic                snap_q, snap_d;
  logic [NUM_REGS-1:0] wr_en, pulse_q;
  logic                idx_ok, idx_ro, err_set, err_clr;
  logic                unused_hw;

  cdc_edge_det u_addr_det (
    .clk(sys_clk), .rst_n(sys_rst_n), .async_i(bus.dr_csr_addr_valid), .sync_negedge(addr_pls)
  );
  cdc_edge_det u_data_det (
    .clk(sys_clk), .rst_n(sys_rst_n), .async_i(bus.dr_csr_data_valid), .sync_negedge(data_pls)
  );

  assign idx       = addr_q[ADDR_W:1];
  assign idx_ok    = 32'(idx) < NUM_REGS;
  assign unused_hw = ^hw_status;

  // Register storage; RO slices are wired straight from hw_status.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (RO_MASK[g]) begin : g_ro
      assign csr_q[g*DATA_W +: DATA_W] = hw_status[g*DATA_W +: DATA_W];
    end else begin : g_rw
      logic [DATA_W-1:0] reg_q;
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)    reg_q <= RST_VAL[g*DATA_W +: DATA_W];
        else if (wr_en[g]) reg_q <= bus.dr_csr_data;
      end
      assign csr_q[g*DATA_W +: DATA_W] = reg_q;
    end
  end

  always_comb begin
    rd_val = '0;
    idx_ro = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(idx) == i) begin
        rd_val = csr_q[i*DATA_W +: DATA_W];
        idx_ro = RO_MASK[i];
      end
    end
  end

  // Access decode; a data pulse always uses the address latched before this edge.
  always_comb begin
    wr_en   = '0;
    err_set = 1'b0;
    err_clr = 1'b0;
    snap_d  = addr_pls;
    if (data_pls) begin
      if (state_q == S_IDLE) begin
        err_set = 1'b1;
      end else if (addr_q[0]) begin
        snap_d = 1'b1;
      end else if (!idx_ok || idx_ro) begin
        err_set = 1'b1;
      end else begin
        snap_d = 1'b1;
        for (int unsigned i = 0; i < NUM_REGS; i++) if (32'(idx) == i) wr_en[i] = 1'b1;
        err_clr = (32'(idx) == TOP_RW) && bus.dr_csr_data[0];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= (ADDR_W+1)'(1);
      data_q  <= '0;
      snap_q  <= 1'b0;
      pulse_q <= '0;
    end else begin
      if (addr_pls) begin
        state_q <= S_ARMED;
        addr_q  <= bus.dr_csr_addr;
      end
      snap_q  <= snap_d;
      if (snap_q) data_q <= rd_val;
      pulse_q <= wr_en;
    end
  end

  assign bus.csr_addr = addr_q;
  assign bus.csr_data = data_q;
  assign csr_wr_pulse = pulse_q;

`ifdef CSR_BANK_ERR_EN
  logic err_q;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)   err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
    else if (err_clr) err_q <= 1'b0;
  end
  assign csr_err = err_q;
`else
  logic unused_err;
  assign unused_err = err_set | err_clr;
  assign csr_err    = 1'b0;
`endif
endmodule

// Two-flop synchroniser with a registered one-cycle falling-edge pulse.
module cdc_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_negedge
);
  logic meta_q, sync_q, prev_q, neg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      neg_q  <= prev_q & ~sync_q;
    end
  end

  assign sync_negedge = neg_q;
endmodule

// File: tb/tb_csr_bank.sv
// Bench for csr_bank: an 8-register bank with RO index 4 and a 5-register bank,
// checked against an access-level model plus directed literal expectations.
module tb_csr_bank;
  localparam int unsigned DW = 32;
  localparam int unsigned NA = 8;
  localparam int unsigned NB = 5;
  localparam int unsigned AW = 3;
  localparam logic [NA-1:0]    RO_A  = 8'h10;
  localparam logic [NA*DW-1:0] RST_A = (NA*DW)'(32'hA5) << (2*DW);
`ifdef CSR_BANK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk, rst_n;
  logic [NA*DW-1:0] hw_a, q_a;
  logic [NB*DW-1:0] hw_b, q_b;
  logic [NA-1:0]    wp_a;
  logic [NB-1:0]    wp_b;
  logic             err_a, err_b;

  csr_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  csr_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  csr_bank #(.NUM_REGS(NA), .DATA_W(DW), .RO_MASK(RO_A), .RST_VAL(RST_A)) u_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus_a), .hw_status(hw_a),
    .csr_q(q_a), .csr_wr_pulse(wp_a), .csr_err(err_a));
  csr_bank #(.NUM_REGS(NB), .DATA_W(DW)) u_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus_b), .hw_status(hw_b),
    .csr_q(q_b), .csr_wr_pulse(wp_b), .csr_err(err_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Access-level model: register contents, latched address, snapshot, error.
  int unsigned m_n  [2] = '{NA, NB};
  logic [7:0]  m_ro [2] = '{RO_A, 8'h00};
  logic [31:0] m_reg [2][8];
  logic        m_armed [2];
  logic [3:0]  m_addr [2];
  logic [31:0] m_data [2];
  logic        m_err [2];

  int          n_chk = 0, n_err = 0;
  int unsigned pcnt [2] = '{0, 0};
  logic [7:0]  plast [2];
  bit          chk_on = 1'b0, pchk_req = 1'b0;
  int          pchk_d = 0, lit_id = 0;
  int unsigned pchk_c0 = 0, pchk_cnt = 0;
  logic [7:0]  pchk_vec = 8'h00;

  function automatic logic [31:0] hw_slice(int d, int i);
    if (d == 0) return hw_a[i*32 +: 32];
    return hw_b[i*32 +: 32];
  endfunction

  function automatic logic [31:0] act_q(int d, int i);
    if (d == 0) return q_a[i*32 +: 32];
    return q_b[i*32 +: 32];
  endfunction

  function automatic logic [31:0] m_rd(int d, int i);
    if (i >= int'(m_n[d])) return 32'h0;
    if (m_ro[d][i]) return hw_slice(d, i);
    return m_reg[d][i];
  endfunction

  function automatic int top_rw(int d);
    int t = 0;
    for (int i = 0; i < int'(m_n[d]); i++) if (!m_ro[d][i]) t = i;
    return t;
  endfunction

  function automatic void m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) m_reg[d][i] = (d == 0 && i == 2) ? 32'hA5 : 32'h0;
      m_armed[d] = 1'b0;
      m_addr[d]  = 4'b0001;
      m_data[d]  = 32'h0;
      m_err[d]   = 1'b0;
    end
  endfunction

  function automatic void m_addr_ev(int d, logic [3:0] a);
    m_addr[d]  = a;
    m_armed[d] = 1'b1;
    m_data[d]  = m_rd(d, int'(a[3:1]));
  endfunction

  function automatic logic [7:0] m_data_ev(int d, logic [31:0] v);
    int         idx = int'(m_addr[d][3:1]);
    logic [7:0] p   = 8'h00;
    if (!m_armed[d]) begin
      if (ERR_EN) m_err[d] = 1'b1;
    end else if (m_addr[d][0]) begin
      m_data[d] = m_rd(d, idx);
    end else if (idx >= int'(m_n[d]) || m_ro[d][idx]) begin
      if (ERR_EN) m_err[d] = 1'b1;
    end else begin
      m_reg[d][idx] = v;
      p[idx] = 1'b1;
      if (ERR_EN && idx == top_rw(d) && v[0]) m_err[d] = 1'b0;
      m_data[d] = m_rd(d, idx);
    end
    return p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Single compare process: pulse monitor, model compare, literal pins.
  always @(negedge clk) begin
    if (|wp_a) begin pcnt[0]++; plast[0] = 8'(wp_a); end
    if (|wp_b) begin pcnt[1]++; plast[1] = 8'(wp_b); end
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < int'(m_n[d]); i++)
          chk($sformatf("csr_q[%0d][%0d]", d, i), act_q(d, i), m_ro[d][i] ? hw_slice(d, i) : m_reg[d][i]);
        chk($sformatf("csr_addr[%0d]", d), d == 0 ? 32'(bus_a.csr_addr) : 32'(bus_b.csr_addr), 32'(m_addr[d]));
        chk($sformatf("csr_data[%0d]", d), d == 0 ? bus_a.csr_data : bus_b.csr_data, m_data[d]);
        chk($sformatf("csr_err[%0d]", d), d == 0 ? 32'(err_a) : 32'(err_b), 32'(m_err[d]));
        chk($sformatf("wr_pulse_idle[%0d]", d), d == 0 ? 32'(wp_a) : 32'(wp_b), 32'h0);
      end
    end
    if (pchk_req) begin
      chk($sformatf("pulse_cycles[%0d]", pchk_d), 32'(pcnt[pchk_d] - pchk_c0), 32'(pchk_cnt));
      if (pchk_cnt != 0) chk($sformatf("pulse_vec[%0d]", pchk_d), 32'(plast[pchk_d]), 32'(pchk_vec));
    end
    case (lit_id)
      1: begin
        chk("rst_q2", q_a[64 +: 32], 32'hA5);
        chk("rst_q3", q_a[96 +: 32], 32'h0);
        chk("rst_addr", 32'(bus_a.csr_addr), 32'h1);
        chk("rst_data", bus_a.csr_data, 32'h0);
        chk("rst_err", 32'(err_a), 32'h0);
      end
      10: begin
        chk("wr3_q", q_a[96 +: 32], 32'hDEADBEEF);
        chk("rd3_data", bus_a.csr_data, 32'hDEADBEEF);
      end
      11: chk("ro4_read", bus_a.csr_data, 32'h1234);
      12: chk("ro4_hold", bus_a.csr_data, 32'h1234);
      13: begin
        chk("ro4_wr_err", 32'(err_a), 32'(ERR_EN));
        chk("ro4_wr_drop", q_a[128 +: 32], 32'h5678);
      end
      14: begin
        chk("w1c_err", 32'(err_a), 32'h0);
        chk("w1c_q7", q_a[224 +: 32], 32'h1);
      end
      15: chk("oob_wr_err", 32'(err_b), 32'(ERR_EN));
      16: chk("oob_rd_data", bus_b.csr_data, 32'h0);
      17: chk("idle_data_err", 32'(err_a), 32'(ERR_EN));
      18: chk("ro4_refresh", bus_a.csr_data, 32'h5678);
      19: begin
        chk("same_cyc_q7", q_a[224 +: 32], 32'hCAFE0001);
        chk("same_cyc_addr", 32'(bus_a.csr_addr), 32'hB);
      end
      20: begin
        chk("mid_rst_addr", 32'(bus_a.csr_addr), 32'h1);
        chk("mid_rst_data", bus_a.csr_data, 32'h0);
        chk("mid_rst_pulse", 32'(wp_a), 32'h0);
        chk("mid_rst_err", 32'(err_a), 32'h0);
        chk("mid_rst_q7", q_a[224 +: 32], 32'h0);
        chk("mid_rst_q2", q_a[64 +: 32], 32'hA5);
        chk("mid_rst_err_b", 32'(err_b), 32'h0);
      end
      21: chk("no_partial_wr", q_a[96 +: 32], 32'h0);
      22: begin
        chk("b_w1c_err", 32'(err_b), 32'h0);
        chk("b_q4", q_b[128 +: 32], 32'h1);
      end
      default: ;
    endcase
  end

  task automatic window();
    @(posedge clk); #1;
    chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_on = 1'b0;
  endtask

  task automatic lit(input int id);
    @(posedge clk); #1;
    lit_id = id;
    @(posedge clk); #1;
    lit_id = 0;
  endtask

  task automatic set_lines(input int d, input bit do_a, input bit do_d, input logic lvl);
    if (d == 0) begin
      if (do_a) bus_a.dr_csr_addr_valid = lvl;
      if (do_d) bus_a.dr_csr_data_valid = lvl;
    end else begin
      if (do_a) bus_b.dr_csr_addr_valid = lvl;
      if (do_d) bus_b.dr_csr_data_valid = lvl;
    end
  endtask

  // One TAP access: present values, drop the valid(s), let the bank settle.
  task automatic drive(input int d, input bit do_a, input logic [3:0] a,
                       input bit do_d, input logic [31:0] v);
    int unsigned c0;
    logic [7:0]  ep;
    @(posedge clk); #1;
    c0 = pcnt[d];
    if (d == 0) begin
      if (do_a) bus_a.dr_csr_addr = a;
      if (do_d) bus_a.dr_csr_data = v;
    end else begin
      if (do_a) bus_b.dr_csr_addr = a;
      if (do_d) bus_b.dr_csr_data = v;
    end
    @(posedge clk); #1;
    set_lines(d, do_a, do_d, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    set_lines(d, do_a, do_d, 1'b1);
    ep = do_d ? m_data_ev(d, v) : 8'h00;
    if (do_a) m_addr_ev(d, a);
    repeat (3) @(posedge clk);
    #1;
    pchk_d = d; pchk_c0 = c0; pchk_cnt = (ep != 8'h00) ? 1 : 0; pchk_vec = ep;
    pchk_req = 1'b1;
    @(posedge clk); #1;
    pchk_req = 1'b0;
    window();
  endtask

  initial begin
    rst_n = 1'b0;
    hw_a = '0;
    hw_a[4*32 +: 32] = 32'h1234;
    hw_b = {5{32'h0F0F_5A5A}};
    bus_a.dr_csr_addr_valid = 1'b1; bus_a.dr_csr_data_valid = 1'b1;
    bus_a.dr_csr_addr = '0;         bus_a.dr_csr_data = '0;
    bus_b.dr_csr_addr_valid = 1'b1; bus_b.dr_csr_data_valid = 1'b1;
    bus_b.dr_csr_addr = '0;         bus_b.dr_csr_data = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    window();
    lit(1);

    drive(0, 1'b0, 4'h0, 1'b1, 32'h77);          // data before any address
    lit(17);
    drive(0, 1'b1, 4'b0110, 1'b0, 32'h0);        // idx 3 WR
    drive(0, 1'b0, 4'h0, 1'b1, 32'hDEADBEEF);
    drive(0, 1'b1, 4'b0111, 1'b0, 32'h0);        // idx 3 RD
    lit(10);

    drive(0, 1'b1, 4'b1001, 1'b0, 32'h0);        // idx 4 RD (RO)
    lit(11);
    @(posedge clk); #1;
    hw_a[4*32 +: 32] = 32'h5678;
    window();
    lit(12);
    drive(0, 1'b0, 4'h0, 1'b1, 32'h0);           // RD data pulse refreshes snapshot
    lit(18);

    drive(0, 1'b1, 4'b1000, 1'b0, 32'h0);        // idx 4 WR (RO)
    drive(0, 1'b0, 4'h0, 1'b1, 32'hFFFF);
    lit(13);
    drive(0, 1'b1, 4'b1110, 1'b0, 32'h0);        // idx 7 WR
    drive(0, 1'b0, 4'h0, 1'b1, 32'h1);
    lit(14);
    drive(0, 1'b0, 4'h0, 1'b1, 32'h3);           // repeat write, no new address
    drive(0, 1'b1, 4'b1011, 1'b1, 32'hCAFE0001); // addr and data on the same edge
    lit(19);

    drive(1, 1'b1, 4'b1100, 1'b0, 32'h0);        // idx 6 WR on 5-reg bank
    drive(1, 1'b0, 4'h0, 1'b1, 32'h11);
    lit(15);
    drive(1, 1'b1, 4'b1101, 1'b0, 32'h0);        // idx 6 RD
    lit(16);
    drive(1, 1'b1, 4'b1000, 1'b0, 32'h0);        // idx 4 WR, highest RW
    drive(1, 1'b0, 4'h0, 1'b1, 32'h1);
    lit(22);

    drive(0, 1'b1, 4'b0110, 1'b0, 32'h0);        // idx 3 WR, then reset mid-write
    @(posedge clk); #1;
    bus_a.dr_csr_data = 32'h12345678;
    @(posedge clk); #1;
    bus_a.dr_csr_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    lit_id = 20;
    @(posedge clk); #1;
    lit_id = 0;
    repeat (2) @(posedge clk);
    #1;
    bus_a.dr_csr_data_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset();
    repeat (8) @(posedge clk);
    window();
    lit(21);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
